uart_rx_param: RTL and testbench



---
 rtl/uart_rx_param.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: DATA_BITS data (LSB first), optional parity, 1-2 stop bits.
// Define UART_RX_BREAK_DETECT_EN to enable the o_Break pulse on an all-zero frame with framing error.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_N    = 4'(STOP_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   dv_q, dv_d;
    logic [DATA_BITS-1:0]   byte_q, byte_d;
    logic                   perr_out_q, perr_out_d;
    logic                   ferr_out_q, ferr_out_d;
    logic [DATA_BITS-1:0]   idx_hit;
    logic                   sample;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                   par_bit_q, par_bit_d;
    logic                   brk_q, brk_d;
`endif

`ifndef SYNTHESIS
    initial begin
        if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) $error("uart_rx_param: illegal CLKS_PER_BIT %0d", CLKS_PER_BIT);
        if (DATA_BITS < 5 || DATA_BITS > 9) $error("uart_rx_param: illegal DATA_BITS %0d", DATA_BITS);
        if (PARITY_MODE < 0 || PARITY_MODE > 2) $error("uart_rx_param: illegal PARITY_MODE %0d", PARITY_MODE);
        if (STOP_BITS < 1 || STOP_BITS > 2) $error("uart_rx_param: illegal STOP_BITS %0d", STOP_BITS);
    end
`endif

    // One-hot decode of the bit index selects the shift-register slot for the current data sample.
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_idx
        assign idx_hit[gi] = (idx_q == 4'(gi));
    end

    assign sample = (cnt_q == LAST_CNT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        dv_d       = 1'b0;
        byte_d     = byte_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
`ifdef UART_RX_BREAK_DETECT_EN
        par_bit_d  = par_bit_q;
        brk_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s_q) begin
                    state_d = START;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                    par_bit_d = 1'b0;
`endif
                end
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (sample) begin
                    cnt_d   = '0;
                    shift_d = (shift_q & ~idx_hit) | (idx_hit & {DATA_BITS{rx_s_q}});
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY_MODE != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                if (sample) begin
                    cnt_d   = '0;
                    perr_d  = (PARITY_MODE == 1) ? (^shift_q ^ rx_s_q) : ~(^shift_q ^ rx_s_q);
                    state_d = STOP;
`ifdef UART_RX_BREAK_DETECT_EN
                    par_bit_d = rx_s_q;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                // idx == STOP_N marks the cycle after the last stop sample: publish the word.
                if (idx_q == STOP_N) begin
                    dv_d       = 1'b1;
                    byte_d     = shift_q;
                    perr_out_d = perr_q;
                    ferr_out_d = ferr_q;
`ifdef UART_RX_BREAK_DETECT_EN
                    brk_d      = ferr_q && (shift_q == '0) && !par_bit_q;
`endif
                    idx_d      = '0;
                    cnt_d      = '0;
                    state_d    = ferr_q ? WAIT_IDLE : IDLE;
                end else if (sample) begin
                    cnt_d = '0;
                    idx_d = idx_q + 4'd1;
                    if (!rx_s_q) ferr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            dv_q       <= 1'b0;
            byte_q     <= '0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_q  <= 1'b0;
            brk_q      <= 1'b0;
`endif
        end else begin
            rx_meta_q  <= i_Rx_Serial;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            dv_q       <= dv_d;
            byte_q     <= byte_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_q  <= par_bit_d;
            brk_q      <= brk_d;
`endif
        end
    end

    assign o_Rx_DV      = dv_q;
    assign o_Rx_Byte    = byte_q;
    assign o_Parity_Err = perr_out_q;
    assign o_Frame_Err  = ferr_out_q;
    assign o_Busy       = (state_q != IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
    assign o_Break      = brk_q;
`else
    assign o_Break      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four receiver configurations driven with directed and random frames,
// each received word compared against a frame-level model of what was put on the line.
module tb_uart_rx_param;

    function automatic int cfg_cpb(input int k);
        return (k == 3) ? 5 : 16;
    endfunction
    function automatic int cfg_db(input int k);
        return (k == 2) ? 7 : (k == 3) ? 9 : 8;
    endfunction
    function automatic int cfg_pm(input int k);
        return (k == 1) ? 1 : (k == 3) ? 2 : 0;
    endfunction
    function automatic int cfg_sb(input int k);
        return (k >= 2) ? 2 : 1;
    endfunction

    typedef struct {
        int         k;
        int         cyc;
        logic [8:0] word;
        logic       perr;
        logic       ferr;
        logic       brk;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rx_line;
    logic [3:0] dv_w, perr_w, ferr_w, brk_w, busy_w;
    logic [8:0] byte_w [4];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         stray_brk = 0;
    ev_t        got_q[$];
    ev_t        exp_q[$];
    ev_t        mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        logic [cfg_db(gi)-1:0] b_w;
        uart_rx_param #(
            .CLKS_PER_BIT(cfg_cpb(gi)),
            .DATA_BITS   (cfg_db(gi)),
            .PARITY_MODE (cfg_pm(gi)),
            .STOP_BITS   (cfg_sb(gi))
        ) u_dut (
            .i_Clock     (clk),
            .i_Reset     (rst),
            .i_Rx_Serial (rx_line[gi]),
            .o_Rx_DV     (dv_w[gi]),
            .o_Rx_Byte   (b_w),
            .o_Parity_Err(perr_w[gi]),
            .o_Frame_Err (ferr_w[gi]),
            .o_Break     (brk_w[gi]),
            .o_Busy      (busy_w[gi])
        );
        assign byte_w[gi] = 9'(b_w);
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (dv_w[k]) begin
                mon_e.k    = k;
                mon_e.cyc  = cyc;
                mon_e.word = byte_w[k];
                mon_e.perr = perr_w[k];
                mon_e.ferr = ferr_w[k];
                mon_e.brk  = brk_w[k];
                got_q.push_back(mon_e);
            end
            if (brk_w[k] && !dv_w[k]) stray_brk++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // All stimulus tasks start and end at 1 time unit after a rising edge.
    task automatic idle(input int k, input int n);
        rx_line[k] = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int k, input logic [8:0] word, input bit par_flip,
                              input logic [1:0] stop_vals, input bit do_exp);
        int         cpb = cfg_cpb(k);
        int         db = cfg_db(k);
        int         pm = cfg_pm(k);
        int         sb = cfg_sb(k);
        int         nb = 0;
        int         n_samples;
        logic [15:0] bits = '0;
        logic [8:0] w = '0;
        logic       p = 1'b0;
        logic       f = 1'b0;
        ev_t        e;
        for (int i = 0; i < db; i++) w[i] = word[i];
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < db; i++) begin bits[nb] = w[i]; nb++; end
        if (pm != 0) begin
            p = ((pm == 1) ? ^w : ~^w) ^ par_flip;
            bits[nb] = p; nb++;
        end
        for (int j = 0; j < sb; j++) begin
            bits[nb] = stop_vals[j]; nb++;
            if (!stop_vals[j]) f = 1'b1;
        end
        n_samples = db + ((pm != 0) ? 1 : 0) + sb;
        e.k    = k;
        e.cyc  = cyc + 5 + cpb / 2 + n_samples * cpb;
        e.word = w;
        e.perr = (pm != 0) && par_flip;
        e.ferr = f;
`ifdef UART_RX_BREAK_DETECT_EN
        e.brk  = f && (w == '0) && !p;
`else
        e.brk  = 1'b0;
`endif
        if (do_exp) exp_q.push_back(e);
        for (int i = 0; i < nb; i++) begin
            rx_line[k] = bits[i];
            repeat (cpb) @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int k);
        int n;
        repeat (3 * cfg_cpb(k) + 20) @(posedge clk);
        #1;
        check_eq("ev_count", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            $display("frame dut%0d word=%h perr=%0b ferr=%0b brk=%0b cyc=%0d (exp word=%h cyc=%0d)",
                     got_q[i].k, got_q[i].word, got_q[i].perr, got_q[i].ferr, got_q[i].brk,
                     got_q[i].cyc, exp_q[i].word, exp_q[i].cyc);
            check_eq("ev_dut",  got_q[i].k,    exp_q[i].k);
            check_eq("ev_word", got_q[i].word, exp_q[i].word);
            check_eq("ev_perr", got_q[i].perr, exp_q[i].perr);
            check_eq("ev_ferr", got_q[i].ferr, exp_q[i].ferr);
            check_eq("ev_brk",  got_q[i].brk,  exp_q[i].brk);
            check_eq("ev_cyc",  got_q[i].cyc,  exp_q[i].cyc);
        end
        if (exp_q.size() > 0) check_eq("hold_word", byte_w[k], exp_q[exp_q.size()-1].word);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int          k0;
        logic [8:0]  wd;
        logic [1:0]  sv;
        bit          fl;
        int          gap;
        rst     = 1'b1;
        rx_line = '1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check_eq("rst_dv",   dv_w[k],   0);
            check_eq("rst_byte", byte_w[k], 0);
            check_eq("rst_perr", perr_w[k], 0);
            check_eq("rst_ferr", ferr_w[k], 0);
            check_eq("rst_brk",  brk_w[k],  0);
            check_eq("rst_busy", busy_w[k], 0);
        end
        rst = 1'b0;
        idle(0, 4);

        // Clean 8N1 frame with exact latency.
        send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b1);
        idle(0, 2);
        drain(0);

        // Even parity: wrong then correct parity bit.
        send_frame(1, 9'h003, 1'b1, 2'b11, 1'b1);
        idle(1, 2);
        send_frame(1, 9'h003, 1'b0, 2'b11, 1'b1);
        idle(1, 2);
        drain(1);

        // Second stop bit low, line stuck low, then a clean frame.
        send_frame(2, 9'h055, 1'b0, 2'b01, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        check_eq("wait_idle_busy", busy_w[2], 1);
        rx_line[2] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("wait_idle_release", busy_w[2], 0);
        idle(2, 2);
        send_frame(2, 9'h02A, 1'b0, 2'b11, 1'b1);
        idle(2, 2);
        drain(2);

        // Four-cycle low glitch on an idle line.
        k0 = cyc;
        rx_line[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_line[0] = 1'b1;
        repeat (k0 + 11 - cyc) @(posedge clk);
        #1;
        check_eq("glitch_busy_mid", busy_w[0], 1);
        @(posedge clk);
        #1;
        check_eq("glitch_busy_end", busy_w[0], 0);
        drain(0);

        // Reset in the middle of the data bits.
        send_frame(0, 9'h05A, 1'b0, 2'b11, 1'b1);
        idle(0, 2);
        drain(0);
        fork
            send_frame(0, 9'h0F0, 1'b0, 2'b11, 1'b0);
            begin
                repeat (5 * 16 + 8) @(posedge clk);
                #2;
                rst = 1'b1;
                #1;
                check_eq("midrst_dv",   dv_w[0],   0);
                check_eq("midrst_byte", byte_w[0], 0);
                check_eq("midrst_perr", perr_w[0], 0);
                check_eq("midrst_ferr", ferr_w[0], 0);
                check_eq("midrst_busy", busy_w[0], 0);
                @(posedge clk);
                #2;
                rst = 1'b0;
            end
        join
        idle(0, 2);
        drain(0);
        send_frame(0, 9'h03C, 1'b0, 2'b11, 1'b1);
        idle(0, 2);
        drain(0);

        // Line held low for three frame times.
        send_frame(0, 9'h000, 1'b0, 2'b00, 1'b1);
        repeat (2 * 10 * 16) @(posedge clk);
        #1;
        idle(0, 4);
        drain(0);

        // Random frames on every configuration, including zero-gap back-to-back frames.
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 6; n++) begin
                wd  = 9'($urandom);
                fl  = (cfg_pm(k) != 0) ? bit'($urandom_range(0, 1)) : 1'b0;
                sv  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
                if (cfg_sb(k) == 1) sv[1] = 1'b1;
                send_frame(k, wd, fl, sv, 1'b1);
                gap = (sv != 2'b11) ? 4 + $urandom_range(0, 3) : $urandom_range(0, 3);
                idle(k, gap);
            end
            drain(k);
        end

        check_eq("stray_break", stray_brk, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
